// File: rtl/led_target_sequencer.sv
// Round sequencer for the LED catcher: lights one pseudo-random target per round,
// scores matching switch presses and ends the game after MAX_MISSES missed rounds.
module led_target_sequencer #(
  parameter int          NUM_LEDS   = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MAX_MISSES = 3,
  parameter int          SCORE_W    = 8
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                tick_in,
  input  logic                start,
  input  logic [NUM_LEDS-1:0] sw,
  output logic [NUM_LEDS-1:0] led,
  output logic [SCORE_W-1:0]  score,
  output logic [2:0]          misses,
  output logic                catch_pulse,
  output logic                game_over,
  output logic [1:0]          state_dbg
);

  localparam int IW = $clog2(NUM_LEDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HIT    = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic [IW-1:0]       tgt;
  logic                tick_d;
  logic                start_d;
  logic [NUM_LEDS-1:0] sw_d;

  logic                round_ev;
  logic                start_ev;
  logic [NUM_LEDS-1:0] sw_rise;
  logic                catch_ev;
  logic [15:0]         lfsr_next;
  logic [IW-1:0]       cand;
  logic [IW-1:0]       new_tgt;
  logic [NUM_LEDS-1:0] new_led;
  logic [2:0]          misses_inc;
  logic [SCORE_W-1:0]  score_sat;

  // tick_in is a level from the divider; either edge marks a round boundary.
  assign round_ev = tick_in != tick_d;
  assign start_ev = start & ~start_d;
  assign sw_rise  = sw & ~sw_d;
  assign catch_ev = sw_rise[tgt];

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // Bumping a repeated candidate guarantees consecutive targets differ.
  assign cand       = lfsr[IW-1:0];
  assign new_tgt    = (cand == tgt) ? cand + IW'(1) : cand;
  assign new_led    = {{(NUM_LEDS-1){1'b0}}, 1'b1} << new_tgt;
  assign misses_inc = misses + 3'd1;
  assign score_sat  = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);

  assign state_dbg = state;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      tgt         <= '0;
      tick_d      <= 1'b0;
      start_d     <= 1'b0;
      sw_d        <= '0;
      led         <= '0;
      score       <= '0;
      misses      <= '0;
      catch_pulse <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      tick_d      <= tick_in;
      start_d     <= start;
      sw_d        <= sw;
      lfsr        <= lfsr_next;
      catch_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ev) begin
            tgt   <= new_tgt;
            led   <= new_led;
            state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (catch_ev) begin
            score       <= score_sat;
            catch_pulse <= 1'b1;
            // A catch landing on a round edge consumes that round immediately.
            if (round_ev) begin
              tgt <= new_tgt;
              led <= new_led;
            end else begin
              led   <= '0;
              state <= S_HIT;
            end
          end else if (round_ev) begin
            misses <= misses_inc;
            if (misses_inc == 3'(MAX_MISSES)) begin
              led       <= '1;
              game_over <= 1'b1;
              state     <= S_OVER;
            end else begin
              tgt <= new_tgt;
              led <= new_led;
            end
          end
        end
        S_HIT: begin
          if (round_ev) begin
            tgt   <= new_tgt;
            led   <= new_led;
            state <= S_ACTIVE;
          end
        end
        S_OVER: begin
          if (start_ev) begin
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
            tgt       <= new_tgt;
            led       <= new_led;
            state     <= S_ACTIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_target_sequencer.sv
// Directed bench for led_target_sequencer: a table of round operations with expected
// score/miss/state/led, plus hand sequences for held switches and mid-game reset.
module tb_led_target_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int ST_IDLE = 0, ST_ACTIVE = 1, ST_HIT = 2, ST_OVER = 3;
  localparam int LED_ZERO = 0, LED_TGT = 1, LED_ONES = 2;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        tick_in;
  logic        start;
  logic [15:0] sw;
  logic [15:0] led;
  logic [1:0]  score;
  logic [2:0]  misses;
  logic        catch_pulse;
  logic        game_over;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  led_target_sequencer #(
    .NUM_LEDS(16), .LFSR_SEED(SEED), .MAX_MISSES(3), .SCORE_W(2)
  ) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .start(start), .sw(sw),
    .led(led), .score(score), .misses(misses), .catch_pulse(catch_pulse),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk_in = ~clk_in;

  // Reference LFSR tracks the value the DUT samples at each upcoming edge.
  logic [15:0] m_lfsr;
  always @(posedge clk_in or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic int pick(input logic [15:0] l, input int cur);
    int c;
    c = int'(l[3:0]);
    if (c == cur) c = (c + 1) % 16;
    return c;
  endfunction

  function automatic logic [15:0] onehot(input int i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  typedef enum logic [2:0] {OP_START, OP_CATCH, OP_WRONG, OP_TICK, OP_BOTH} op_t;

  typedef struct {
    op_t op;
    bit  load;
    int  e_score;
    int  e_miss;
    int  e_go;
    int  e_state;
    int  e_led;
    int  e_cp;
  } vec_t;

  vec_t vecs[25];
  int   exp_tgt;
  int   prev_tgt;
  int   first_tgt;

  function automatic vec_t mk(input op_t op, input bit ld, input int sc, input int mi,
                              input int go, input int st, input int lk, input int cp);
    vec_t v;
    v.op = op; v.load = ld; v.e_score = sc; v.e_miss = mi;
    v.e_go = go; v.e_state = st; v.e_led = lk; v.e_cp = cp;
    return v;
  endfunction

  function automatic logic [15:0] exp_led(input int kind, input int t);
    if (kind == LED_TGT)  return onehot(t);
    if (kind == LED_ONES) return 16'hFFFF;
    return 16'h0000;
  endfunction

  // Four tick toggles in IDLE; tick_in ends low again.
  task automatic idle_ticks();
    for (int i = 0; i < 4; i++) begin
      tick_in = ~tick_in;
      step();
      chk("idle_led", led, 0);
      chk("idle_state", state_dbg, ST_IDLE);
      chk("idle_misses", misses, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_misses"}, misses, 0);
    chk({tag, "_cp"}, catch_pulse, 0);
    chk({tag, "_go"}, game_over, 0);
    chk({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    vecs[0]  = mk(OP_START, 1, 0, 0, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[1]  = mk(OP_WRONG, 0, 0, 0, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[2]  = mk(OP_CATCH, 0, 1, 0, 0, ST_HIT,    LED_ZERO, 1);
    vecs[3]  = mk(OP_WRONG, 0, 1, 0, 0, ST_HIT,    LED_ZERO, 0);
    vecs[4]  = mk(OP_TICK,  1, 1, 0, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[5]  = mk(OP_BOTH,  1, 2, 0, 0, ST_ACTIVE, LED_TGT,  1);
    vecs[6]  = mk(OP_START, 0, 2, 0, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[7]  = mk(OP_TICK,  1, 2, 1, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[8]  = mk(OP_CATCH, 0, 3, 1, 0, ST_HIT,    LED_ZERO, 1);
    vecs[9]  = mk(OP_START, 0, 3, 1, 0, ST_HIT,    LED_ZERO, 0);
    vecs[10] = mk(OP_TICK,  1, 3, 1, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[11] = mk(OP_CATCH, 0, 3, 1, 0, ST_HIT,    LED_ZERO, 1);
    vecs[12] = mk(OP_TICK,  1, 3, 1, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[13] = mk(OP_BOTH,  1, 3, 1, 0, ST_ACTIVE, LED_TGT,  1);
    vecs[14] = mk(OP_CATCH, 0, 3, 1, 0, ST_HIT,    LED_ZERO, 1);
    vecs[15] = mk(OP_TICK,  1, 3, 1, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[16] = mk(OP_TICK,  1, 3, 2, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[17] = mk(OP_TICK,  0, 3, 3, 1, ST_OVER,   LED_ONES, 0);
    vecs[18] = mk(OP_TICK,  0, 3, 3, 1, ST_OVER,   LED_ONES, 0);
    vecs[19] = mk(OP_CATCH, 0, 3, 3, 1, ST_OVER,   LED_ONES, 0);
    vecs[20] = mk(OP_START, 1, 0, 0, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[21] = mk(OP_TICK,  1, 0, 1, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[22] = mk(OP_TICK,  1, 0, 2, 0, ST_ACTIVE, LED_TGT,  0);
    vecs[23] = mk(OP_TICK,  0, 0, 3, 1, ST_OVER,   LED_ONES, 0);
    vecs[24] = mk(OP_START, 1, 0, 0, 0, ST_ACTIVE, LED_TGT,  0);

    rst = 1'b0; tick_in = 1'b0; start = 1'b0; sw = '0;
    exp_tgt = 0; first_tgt = 0;
    repeat (5) step();
    check_all_zero("reset");
    rst = 1'b1;
    step();
    check_all_zero("post_release");
    idle_ticks();

    for (int i = 0; i < 25; i++) begin
      prev_tgt = exp_tgt;
      case (vecs[i].op)
        OP_START: start = 1'b1;
        OP_CATCH: sw = onehot(exp_tgt);
        OP_WRONG: sw = onehot((exp_tgt + 5) % 16);
        OP_TICK:  tick_in = ~tick_in;
        OP_BOTH:  begin sw = onehot(exp_tgt); tick_in = ~tick_in; end
        default:  ;
      endcase
      if (vecs[i].load) exp_tgt = pick(m_lfsr, exp_tgt);
      if (i == 0) first_tgt = exp_tgt;
      step();
      chk($sformatf("v%0d_score", i), score, vecs[i].e_score);
      chk($sformatf("v%0d_misses", i), misses, vecs[i].e_miss);
      chk($sformatf("v%0d_go", i), game_over, vecs[i].e_go);
      chk($sformatf("v%0d_state", i), state_dbg, vecs[i].e_state);
      chk($sformatf("v%0d_led", i), led, exp_led(vecs[i].e_led, exp_tgt));
      chk($sformatf("v%0d_cp", i), catch_pulse, vecs[i].e_cp);
      if (vecs[i].load && i > 0)
        chk($sformatf("v%0d_tgt_differs", i), led != onehot(prev_tgt), 1);
      start = 1'b0;
      sw = '0;
      step();
      chk($sformatf("v%0d_cp_clear", i), catch_pulse, 0);
      chk($sformatf("v%0d_hold_led", i), led, exp_led(vecs[i].e_led, exp_tgt));
    end

    // Held switches: every bit high catches once, then holding them catches nothing.
    sw = 16'hFFFF;
    step();
    chk("held_first_score", score, 1);
    chk("held_first_cp", catch_pulse, 1);
    chk("held_first_state", state_dbg, ST_HIT);
    step();
    chk("held_cp_one_cycle", catch_pulse, 0);
    tick_in = ~tick_in;
    exp_tgt = pick(m_lfsr, exp_tgt);
    step();
    chk("held_round_state", state_dbg, ST_ACTIVE);
    chk("held_round_led", led, onehot(exp_tgt));
    chk("held_round_score", score, 1);
    step();
    chk("held_no_recatch_score", score, 1);
    chk("held_no_recatch_cp", catch_pulse, 0);
    chk("held_no_recatch_state", state_dbg, ST_ACTIVE);
    sw = '0;
    step();
    sw = onehot(exp_tgt);
    step();
    chk("rearm_score", score, 2);
    chk("rearm_state", state_dbg, ST_HIT);
    sw = '0;
    tick_in = ~tick_in;
    exp_tgt = pick(m_lfsr, exp_tgt);
    step();
    chk("pre_reset_state", state_dbg, ST_ACTIVE);
    chk("pre_reset_led", led, onehot(exp_tgt));

    // Asynchronous reset mid-cycle, then a replay of the first game start.
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick_in = 1'b0;
    exp_tgt = 0;
    repeat (5) step();
    rst = 1'b1;
    step();
    check_all_zero("re_release");
    idle_ticks();
    start = 1'b1;
    exp_tgt = pick(m_lfsr, exp_tgt);
    step();
    start = 1'b0;
    chk("replay_state", state_dbg, ST_ACTIVE);
    chk("replay_first_target", led, onehot(first_tgt));
    chk("replay_model_target", led, onehot(exp_tgt));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
